// File: rtl/seg_pkg.sv
// Shared encodings for the seven-segment scan controller: FSM states,
// active-low glyph constants (bit6=G .. bit0=A) and segment bit positions.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex code to active-low seven-segment pattern; one instance
// is shared by all digits through the scan controller's digit mux.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Glyph lookup for hex digits 0-F
    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'h0:    seg = GLYPH_0;
            4'h1:    seg = GLYPH_1;
            4'h2:    seg = GLYPH_2;
            4'h3:    seg = GLYPH_3;
            4'h4:    seg = GLYPH_4;
            4'h5:    seg = GLYPH_5;
            4'h6:    seg = GLYPH_6;
            4'h7:    seg = GLYPH_7;
            4'h8:    seg = GLYPH_8;
            4'h9:    seg = GLYPH_9;
            4'hA:    seg = GLYPH_A;
            4'hB:    seg = GLYPH_B;
            4'hC:    seg = GLYPH_C;
            4'hD:    seg = GLYPH_D;
            4'hE:    seg = GLYPH_E;
            4'hF:    seg = GLYPH_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with a
// ghosting-guard blank per slot and frame-aligned (tear-free) digit loads.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};
    localparam logic [4*NUM_DIGITS-1:0] BUF_ZERO = {(4*NUM_DIGITS){1'b0}};

    scan_state_e              state_r, state_s;
    logic [CNT_W-1:0]         cnt_r, cnt_s, cnt_inc_s;
    logic [IDX_W-1:0]         idx_r, idx_s;
    logic [4*NUM_DIGITS-1:0]  active_r, active_s;
    logic [4*NUM_DIGITS-1:0]  shadow_r, shadow_s;
    logic                     pending_r, pending_s;
    logic                     frame_end_s, commit_s, accept_s;
    logic [3:0]               code_s;
    logic [6:0]               glyph_s, seg_s;
    logic [NUM_DIGITS-1:0]    an_s;
    logic [NUM_DIGITS-1:0]    an_r;
    logic [6:0]               seg_r;
    logic                     load_ready_r;

    assign an_out     = an_r;
    assign seg_out    = seg_r;
    assign digit_idx  = idx_r;
    assign load_ready = load_ready_r;

    // Scan sequencing: slot counter, digit index and blank/show phase
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        cnt_inc_s = cnt_r + CNT_ONE;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                idx_s = IDX_ZERO;
                if (enable) begin
                    state_s = ST_BLANK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BLANK, ST_SHOW: begin
                if (!enable) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    idx_s   = IDX_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = CNT_ZERO;
                    if (idx_r == IDX_LAST) begin
                        idx_s = IDX_ZERO;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    cnt_s = cnt_inc_s;
                    if (cnt_inc_s >= CNT_BLANK) begin
                        state_s = ST_SHOW;
                    end else begin
                        state_s = ST_BLANK;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                idx_s   = IDX_ZERO;
            end
        endcase
    end

    // Load buffers: capture into shadow, promote to active only at a frame edge or while idle
    always_comb begin
        frame_end_s = (state_r != ST_IDLE) && (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
        commit_s    = pending_r && (frame_end_s || (state_r == ST_IDLE));
        accept_s    = load_valid && !pending_r;
        active_s    = active_r;
        shadow_s    = shadow_r;
        pending_s   = pending_r;
        if (commit_s) begin
            active_s  = shadow_r;
            pending_s = 1'b0;
        end else if (accept_s) begin
            shadow_s  = load_data;
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end
    end

    // Digit mux feeding the single shared decoder, using next-cycle buffer and index
    always_comb begin
        code_s = active_s[{idx_s, 2'b00} +: 4];
    end

    seg_hex_decode u_dec (
        .code (code_s),
        .seg  (glyph_s)
    );

    // Next output values; segments are pre-driven during blank so the anode edge is clean
    always_comb begin
        an_s = AN_OFF;
        if ((state_s == ST_SHOW) && !blank_mask[idx_s]) begin
            an_s[idx_s] = 1'b0;
        end else begin
            an_s = AN_OFF;
        end
        if (state_s == ST_IDLE) begin
            seg_s = SEG_OFF;
        end else begin
            seg_s = glyph_s;
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            idx_r        <= IDX_ZERO;
            active_r     <= BUF_ZERO;
            shadow_r     <= BUF_ZERO;
            pending_r    <= 1'b0;
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            load_ready_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            idx_r        <= idx_s;
            active_r     <= active_s;
            shadow_r     <= shadow_s;
            pending_r    <= pending_s;
            an_r         <= an_s;
            seg_r        <= seg_s;
            load_ready_r <= !pending_s;
        end
    end

endmodule
